round_scheduler: RTL and testbench

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/round_scheduler.sv | 153 +++++++++++++++
 tb/tb_round_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/round_scheduler.sv
// rtl/round_scheduler.sv - game round sequencer: countdown, play, result and game-over flow
// Tracks rounds, score, lives and the wall index/speed handed to the wall renderer.
module round_scheduler #(
   parameter int NUM_WALLS           = 10,
   parameter int MAX_FRAMES_PER_TICK = 15,
   parameter int MIN_FRAMES_PER_TICK = 2,
   parameter int COUNTDOWN_FRAMES    = 180,
   parameter int RESULT_FRAMES       = 120,
   parameter int MAX_LIVES           = 3
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic       new_frame_in,
   input  logic       wall_done_in,
   input  logic       collision_in,
   output logic [3:0] wall_idx_out,
   output logic [3:0] wall_tick_frequency_out,
   output logic       wall_enable_out,
   output logic       wall_rst_out,
   output logic [7:0] round_out,
   output logic [7:0] score_out,
   output logic [1:0] lives_out,
   output logic [2:0] game_state_out
);

   localparam int CNT_MAX = (COUNTDOWN_FRAMES > RESULT_FRAMES) ? COUNTDOWN_FRAMES : RESULT_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_PLAY      = 3'd2,
      S_RESULT    = 3'd3,
      S_GAME_OVER = 3'd4
   } state_t;

   state_t             r_state, w_state;
   logic [3:0]         r_idx, w_idx;
   logic [3:0]         r_freq, w_freq;
   logic               r_enable, w_enable;
   logic               r_wall_rst, w_wall_rst;
   logic [7:0]         r_round, w_round;
   logic [7:0]         r_score, w_score;
   logic [1:0]         r_lives, w_lives;
   logic [CNT_W-1:0]   r_cnt, w_cnt;
   logic               r_hit, w_hit;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_idx      <= 4'd0;
         r_freq     <= 4'(MAX_FRAMES_PER_TICK);
         r_enable   <= 1'b0;
         r_wall_rst <= 1'b0;
         r_round    <= 8'd0;
         r_score    <= 8'd0;
         r_lives    <= 2'(MAX_LIVES);
         r_cnt      <= '0;
         r_hit      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_idx      <= w_idx;
         r_freq     <= w_freq;
         r_enable   <= w_enable;
         r_wall_rst <= w_wall_rst;
         r_round    <= w_round;
         r_score    <= w_score;
         r_lives    <= w_lives;
         r_cnt      <= w_cnt;
         r_hit      <= w_hit;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_idx      = r_idx;
      w_freq     = r_freq;
      w_wall_rst = 1'b0;
      w_round    = r_round;
      w_score    = r_score;
      w_lives    = r_lives;
      w_cnt      = r_cnt;
      w_hit      = r_hit;
      case (r_state)
         S_IDLE, S_GAME_OVER: begin
            if (start_in) begin
               w_state = S_COUNTDOWN;
               w_round = 8'd0;
               w_score = 8'd0;
               w_lives = 2'(MAX_LIVES);
               w_idx   = 4'd0;
               w_freq  = 4'(MAX_FRAMES_PER_TICK);
               w_cnt   = '0;
               w_hit   = 1'b0;
            end
         end
         S_COUNTDOWN: begin
            if (new_frame_in) begin
               if (r_cnt == CNT_W'(COUNTDOWN_FRAMES - 1)) begin
                  w_state    = S_PLAY;
                  w_cnt      = '0;
                  w_wall_rst = 1'b1;
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         S_PLAY: begin
            // The hit flag also captures a same-cycle collision so RESULT knows whether to speed up.
            w_hit = r_hit | collision_in;
            if (wall_done_in) begin
               w_state = S_RESULT;
               if (r_hit || collision_in) begin
                  if (r_lives != 2'd0) w_lives = r_lives - 1'b1;
               end else if (r_score != 8'hFF) begin
                  w_score = r_score + 1'b1;
               end
            end
         end
         S_RESULT: begin
            if (new_frame_in) begin
               if (r_cnt == CNT_W'(RESULT_FRAMES - 1)) begin
                  w_cnt = '0;
                  if (r_lives == 2'd0) begin
                     w_state = S_GAME_OVER;
                  end else begin
                     w_state = S_COUNTDOWN;
                     w_hit   = 1'b0;
                     if (r_round != 8'hFF) w_round = r_round + 1'b1;
                     w_idx = (r_idx == 4'(NUM_WALLS - 1)) ? 4'd0 : r_idx + 1'b1;
                     if (!r_hit && (r_freq > 4'(MIN_FRAMES_PER_TICK))) w_freq = r_freq - 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
      w_enable = (w_state == S_PLAY);
   end

   assign wall_idx_out            = r_idx;
   assign wall_tick_frequency_out = r_freq;
   assign wall_enable_out         = r_enable;
   assign wall_rst_out            = r_wall_rst;
   assign round_out               = r_round;
   assign score_out               = r_score;
   assign lives_out               = r_lives;
   assign game_state_out          = r_state;

endmodule

// File: tb/tb_round_scheduler.sv
// tb/tb_round_scheduler.sv - directed self-checking bench for round_scheduler
// Inputs change and outputs are sampled on the falling clock edge.
module tb_round_scheduler;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b0;
   logic       start_in = 1'b0;
   logic       new_frame_in = 1'b0;
   logic       wall_done_in = 1'b0;
   logic       collision_in = 1'b0;
   logic [3:0] wall_idx_out;
   logic [3:0] wall_tick_frequency_out;
   logic       wall_enable_out;
   logic       wall_rst_out;
   logic [7:0] round_out;
   logic [7:0] score_out;
   logic [1:0] lives_out;
   logic [2:0] game_state_out;

   int checks = 0;
   int failures = 0;

   round_scheduler dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .start_in(start_in),
      .new_frame_in(new_frame_in),
      .wall_done_in(wall_done_in),
      .collision_in(collision_in),
      .wall_idx_out(wall_idx_out),
      .wall_tick_frequency_out(wall_tick_frequency_out),
      .wall_enable_out(wall_enable_out),
      .wall_rst_out(wall_rst_out),
      .round_out(round_out),
      .score_out(score_out),
      .lives_out(lives_out),
      .game_state_out(game_state_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         new_frame_in = 1'b1;
         @(negedge clk_in);
         new_frame_in = 1'b0;
      end
   endtask

   task automatic pulse_done();
      wall_done_in = 1'b1;
      @(negedge clk_in);
      wall_done_in = 1'b0;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, game_state_out, 0);
      chk({tag, "_idx"}, wall_idx_out, 0);
      chk({tag, "_freq"}, wall_tick_frequency_out, 15);
      chk({tag, "_en"}, wall_enable_out, 0);
      chk({tag, "_wrst"}, wall_rst_out, 0);
      chk({tag, "_round"}, round_out, 0);
      chk({tag, "_score"}, score_out, 0);
      chk({tag, "_lives"}, lives_out, 3);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      check_reset_values("rst");
      rst_in = 1'b1;
      new_frame_in = 1'b1;
      wall_done_in = 1'b1;
      repeat (3) @(negedge clk_in);
      new_frame_in = 1'b0;
      wall_done_in = 1'b0;
      chk("idle_hold", game_state_out, 0);

      // Round 1: countdown with ignored inputs mid-way, then a cleared wall
      pulse_start();
      chk("start_state", game_state_out, 1);
      frames(100);
      collision_in = 1'b1;
      wall_done_in = 1'b1;
      start_in     = 1'b1;
      @(negedge clk_in);
      collision_in = 1'b0;
      wall_done_in = 1'b0;
      start_in     = 1'b0;
      chk("cd_ignore_state", game_state_out, 1);
      frames(79);
      chk("cd_179_state", game_state_out, 1);
      chk("cd_179_wrst", wall_rst_out, 0);
      chk("cd_179_en", wall_enable_out, 0);
      frames(1);
      chk("play_state", game_state_out, 2);
      chk("play_wrst", wall_rst_out, 1);
      chk("play_en", wall_enable_out, 1);
      @(negedge clk_in);
      chk("play_wrst_off", wall_rst_out, 0);
      chk("play_en_hold", wall_enable_out, 1);
      pulse_done();
      chk("r1_result_state", game_state_out, 3);
      chk("r1_result_score", score_out, 1);
      chk("r1_result_en", wall_enable_out, 0);
      frames(119);
      chk("r1_119_state", game_state_out, 3);
      frames(1);
      chk("r1_state", game_state_out, 1);
      chk("r1_score", score_out, 1);
      chk("r1_round", round_out, 1);
      chk("r1_idx", wall_idx_out, 1);
      chk("r1_freq", wall_tick_frequency_out, 14);
      chk("r1_lives", lives_out, 3);

      // Round 2: earlier collision then wall done
      frames(180);
      collision_in = 1'b1;
      @(negedge clk_in);
      collision_in = 1'b0;
      repeat (2) @(negedge clk_in);
      pulse_done();
      chk("r2_lives", lives_out, 2);
      chk("r2_score", score_out, 1);
      frames(120);
      chk("r2_state", game_state_out, 1);
      chk("r2_round", round_out, 2);
      chk("r2_idx", wall_idx_out, 2);
      chk("r2_freq", wall_tick_frequency_out, 14);

      // Round 3: collision in the same cycle as wall done
      frames(180);
      collision_in = 1'b1;
      pulse_done();
      collision_in = 1'b0;
      chk("r3_lives", lives_out, 1);
      frames(120);
      chk("r3_round", round_out, 3);
      chk("r3_freq", wall_tick_frequency_out, 14);

      // Round 4: last life lost, game over
      frames(180);
      collision_in = 1'b1;
      pulse_done();
      collision_in = 1'b0;
      chk("r4_lives", lives_out, 0);
      frames(120);
      chk("go_state", game_state_out, 4);
      chk("go_round", round_out, 3);
      chk("go_lives", lives_out, 0);
      frames(5);
      chk("go_frame_ignore", game_state_out, 4);
      pulse_start();
      chk("restart_state", game_state_out, 1);
      chk("restart_round", round_out, 0);
      chk("restart_score", score_out, 0);
      chk("restart_lives", lives_out, 3);
      chk("restart_idx", wall_idx_out, 0);
      chk("restart_freq", wall_tick_frequency_out, 15);

      // Consecutive cleared rounds: index wrap and speed saturation
      for (int k = 1; k <= 14; k++) begin
         frames(180);
         pulse_done();
         frames(120);
         chk($sformatf("clr%0d_idx", k), wall_idx_out, k % 10);
         chk($sformatf("clr%0d_freq", k), wall_tick_frequency_out, (15 - k < 2) ? 2 : 15 - k);
         chk($sformatf("clr%0d_score", k), score_out, k);
      end

      // Asynchronous reset in PLAY with collision held high
      frames(180);
      chk("pre_rst_state", game_state_out, 2);
      collision_in = 1'b1;
      @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1 check_reset_values("async_rst");
      @(negedge clk_in);
      collision_in = 1'b0;
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      chk("post_rst_state", game_state_out, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
